mc_control_unit: RTL and testbench
==================================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter ALUCTL_W, default 3, ALUControl width; values >3 zero-extend the codes.
REQ-002 SHALL have parameter WAIT_W, default 4, memory-wait counter width.
REQ-003 SHALL have parameter MAX_WAIT, default 15, wait-cycle limit; 0 disables timeout.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 Opcode, Funct  in  6 each  instruction fields from the IR, stable from DECODE until return to FETCH.
REQ-007 mem_ready  in  1  memory completes the current access this cycle.
REQ-008 MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, RegWrite, Branch, BranchNe, ImmZext  out  1 each  datapath controls.
REQ-009 PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 ALUSrcB  out  2  00 regB, 01 const 4, 10 ext imm, 11 sext imm<<2.
REQ-011 ALUControl  out  ALUCTL_W  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-012 illegal, bus_err  out  1 each  sticky fault flags.

Function
REQ-013 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, ALUWB, EXEC_I, IWB, BRANCH, JUMP, TRAP; outputs decoded from state plus Opcode/Funct/mem_ready only.
REQ-014 Unlisted outputs SHALL be 0 in every state; ALUControl defaults to add.
REQ-015 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00; IRWrite=PCWrite=mem_ready; mem_ready=1 -> DECODE, else hold.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, add; next: LW(100011)/SW(101011) -> MEMADR, R(000000) -> EXEC_R, ADDI(001000)/ANDI(001100)/ORI(001101) -> EXEC_I, BEQ(000100)/BNE(000101) -> BRANCH, J(000010) -> JUMP, other -> TRAP.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, add; LW -> MEMRD, SW -> MEMWR.
REQ-018 MEMRD: IorD=1; mem_ready=1 -> MEMWB, else hold. MEMWB: MemtoReg=1, RegDst=0, RegWrite=1 -> FETCH.
REQ-019 MEMWR: IorD=1, MemWrite=1 held until mem_ready=1, then -> FETCH.
REQ-020 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); unknown Funct -> TRAP, else -> ALUWB.
REQ-021 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
REQ-022 EXEC_I: ALUSrcA=1, ALUSrcB=10; ADDI add, ANDI and, ORI or; ImmZext=1 for ANDI/ORI -> IWB. IWB: RegDst=0, RegWrite=1 -> FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch=1 (BEQ) or BranchNe=1 (BNE) -> FETCH; datapath gates PCWrite with Zero.
REQ-024 Wait counter SHALL clear on entering any state and increment each cycle in FETCH/MEMRD/MEMWR with mem_ready=0; reaching MAX_WAIT (MAX_WAIT>0) -> TRAP, bus_err set.
REQ-025 mem_ready on the same cycle the counter reaches MAX_WAIT SHALL win (normal transition, no bus_err).
REQ-026 TRAP: all write enables 0; illegal or bus_err held 1; remains until rst.

Reset
REQ-027 rst=1 at a clock edge SHALL force FETCH, clear counter, illegal, bus_err, from any state including mid-access; rst dominates mem_ready.

Configuration
REQ-028 MC_CTRL_JUMP_EN defined: J -> JUMP, PCSrc=10, PCWrite=1 -> FETCH; undefined: J treated as illegal -> TRAP, JUMP state absent.

Structure
REQ-029 Package mc_ctrl_pkg SHALL hold state enum, opcode/funct constants, ALUControl, PCSrc and ALUSrcB encodings.
REQ-030 Funct-to-ALUControl decode SHALL be sub-module mc_alu_decoder (combinational, valid flag out).

Verification
REQ-031 LW, mem_ready always 1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1 MemtoReg=1 in cycle 5.
REQ-032 SW with mem_ready low 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then FETCH.
REQ-033 R-type Funct=100010 -> ALUControl=110 in EXEC_R, RegDst=1 RegWrite=1 in ALUWB; Funct=111111 -> TRAP, illegal=1.
REQ-034 ORI -> ImmZext=1, ALUControl=001; BNE -> BranchNe=1, PCSrc=01, ALUControl=110.
REQ-035 MAX_WAIT=15, mem_ready held 0 in FETCH -> TRAP after 15 cycles, bus_err=1; rst -> FETCH, flags 0.
REQ-036 Opcode 000010 with and without MC_CTRL_JUMP_EN -> PCSrc=10 PCWrite=1, resp. TRAP with illegal=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: FSM state encoding,
// instruction field constants and datapath select encodings.
// The JUMP state only exists when MC_CTRL_JUMP_EN is defined.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC_R,
    ALUWB,
    EXEC_I,
    IWB,
    BRANCH,
`ifdef MC_CTRL_JUMP_EN
    JUMP,
`endif
    TRAP
  } state_t;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes (native 3-bit form)
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  // ALU operation for the immediate arithmetic/logic instructions
  function automatic logic [2:0] alu_for_imm(input logic [5:0] opcode);
    case (opcode)
      OP_ANDI: alu_for_imm = ALU_AND;
      OP_ORI:  alu_for_imm = ALU_OR;
      default: alu_for_imm = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational Funct-to-ALU-operation decoder for R-type instructions.
// valid is low for any Funct the datapath does not implement.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl,
  output logic       valid
);

  // Map each supported Funct code to its ALU operation
  always_comb begin
    alu_ctl = ALU_ADD;
    valid   = 1'b1;
    case (funct)
      FN_ADD:  alu_ctl = ALU_ADD;
      FN_SUB:  alu_ctl = ALU_SUB;
      FN_AND:  alu_ctl = ALU_AND;
      FN_OR:   alu_ctl = ALU_OR;
      FN_SLT:  alu_ctl = ALU_SLT;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-style control unit. Moore FSM sequencing fetch, decode,
// memory, R-type, immediate, branch and (optionally) jump instructions,
// with a memory-wait watchdog and sticky illegal/bus_err fault flags.
// Optional feature: define MC_CTRL_JUMP_EN to support the J instruction;
// without it J is decoded as illegal.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTL_W = 3,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          Opcode,
  input  logic [5:0]          Funct,
  input  logic                mem_ready,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                IorD,
  output logic                ALUSrcA,
  output logic                IRWrite,
  output logic                MemWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic                Branch,
  output logic                BranchNe,
  output logic                ImmZext,
  output logic [1:0]          PCSrc,
  output logic [1:0]          ALUSrcB,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                illegal,
  output logic                bus_err
);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic              timeout_hit;
  logic [2:0]        fn_alu;
  logic              fn_valid;
  logic [2:0]        alu_code;

  mc_alu_decoder u_alu_decoder (
    .funct   (Funct),
    .alu_ctl (fn_alu),
    .valid   (fn_valid)
  );

  // The watchdog fires when this cycle's stall would bring the count to MAX_WAIT;
  // the count saturates so a disabled watchdog never wraps.
  assign wait_inc    = (wait_cnt == '1) ? wait_cnt : wait_cnt + WAIT_W'(1);
  assign timeout_hit = (MAX_WAIT > 0) && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  // State sequencing, wait counter and sticky fault flags; the counter clears on every transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      wait_cnt <= '0;
      case (state)
        FETCH: begin
          if (mem_ready) begin
            state <= DECODE;
          end else if (timeout_hit) begin
            state   <= TRAP;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        DECODE: begin
          case (Opcode)
            OP_LW, OP_SW:             state <= MEMADR;
            OP_RTYPE:                 state <= EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI: state <= EXEC_I;
            OP_BEQ, OP_BNE:           state <= BRANCH;
`ifdef MC_CTRL_JUMP_EN
            OP_J:                     state <= JUMP;
`endif
            default: begin
              state   <= TRAP;
              illegal <= 1'b1;
            end
          endcase
        end
        MEMADR: begin
          if (Opcode == OP_LW) begin
            state <= MEMRD;
          end else if (Opcode == OP_SW) begin
            state <= MEMWR;
          end else begin
            state   <= TRAP;
            illegal <= 1'b1;
          end
        end
        MEMRD: begin
          if (mem_ready) begin
            state <= MEMWB;
          end else if (timeout_hit) begin
            state   <= TRAP;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        MEMWB: state <= FETCH;
        MEMWR: begin
          if (mem_ready) begin
            state <= FETCH;
          end else if (timeout_hit) begin
            state   <= TRAP;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        EXEC_R: begin
          if (fn_valid) begin
            state <= ALUWB;
          end else begin
            state   <= TRAP;
            illegal <= 1'b1;
          end
        end
        ALUWB:  state <= FETCH;
        EXEC_I: state <= IWB;
        IWB:    state <= FETCH;
        BRANCH: state <= FETCH;
`ifdef MC_CTRL_JUMP_EN
        JUMP:   state <= FETCH;
`endif
        TRAP:   state <= TRAP;
        default: begin
          state   <= TRAP;
          illegal <= 1'b1;
        end
      endcase
    end
  end

  // Datapath controls decoded from the current state, with Opcode/Funct/mem_ready refinements
  always_comb begin
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    Branch   = 1'b0;
    BranchNe = 1'b0;
    ImmZext  = 1'b0;
    PCSrc    = PCSRC_ALU;
    ALUSrcB  = SRCB_REGB;
    alu_code = ALU_ADD;
    case (state)
      FETCH: begin
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: ALUSrcB = SRCB_BROFF;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEMRD: IorD = 1'b1;
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXEC_R: begin
        ALUSrcA  = 1'b1;
        alu_code = fn_valid ? fn_alu : ALU_ADD;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      EXEC_I: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_IMM;
        alu_code = alu_for_imm(Opcode);
        ImmZext  = (Opcode == OP_ANDI) || (Opcode == OP_ORI);
      end
      IWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA  = 1'b1;
        alu_code = ALU_SUB;
        PCSrc    = PCSRC_ALUOUT;
        Branch   = (Opcode == OP_BEQ);
        BranchNe = (Opcode == OP_BNE);
      end
`ifdef MC_CTRL_JUMP_EN
      JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCWrite = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign ALUControl = ALUCTL_W'(alu_code);

endmodule

// File: tb/tb_mc_control_unit.sv
// Testbench for mc_control_unit. Each scenario builds a cycle-by-cycle script
// of inputs and expected controls from the instruction-level behaviour, then
// plays it against the DUT. Honours MC_CTRL_JUMP_EN for the J expectations.
module tb_mc_control_unit;

  typedef struct packed {
    logic       memtoreg, regdst, iord, alusrca, irwrite, memwrite;
    logic       pcwrite, regwrite, branch, branchne, immzext;
    logic [1:0] pcsrc, alusrcb;
    logic [2:0] aluctl;
    logic       illegal, buserr;
  } ctl_t;

  typedef struct packed {
    logic       chk, rst, mr;
    logic [5:0] op, fn;
    ctl_t       exp;
  } step_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] Opcode = '0;
  logic [5:0] Funct = '0;
  logic       mem_ready = 1'b0;
  logic       MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite;
  logic       RegWrite, Branch, BranchNe, ImmZext, illegal, bus_err;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUControl;
  ctl_t       obs;
  step_t      q[$];
  int         tests = 0;
  int         fails = 0;

  mc_control_unit dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .mem_ready(mem_ready),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .IorD(IorD), .ALUSrcA(ALUSrcA),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .Branch(Branch), .BranchNe(BranchNe), .ImmZext(ImmZext), .PCSrc(PCSrc),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  assign obs = {MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, RegWrite,
                Branch, BranchNe, ImmZext, PCSrc, ALUSrcB, ALUControl, illegal, bus_err};

  // Reference model: expected controls for each phase of an instruction
  function automatic ctl_t base();
    ctl_t e = '0;
    e.aluctl = 3'b010;
    return e;
  endfunction
  function automatic ctl_t e_fetch(input logic mr);
    ctl_t e = base();
    e.alusrcb = 2'b01; e.irwrite = mr; e.pcwrite = mr;
    return e;
  endfunction
  function automatic ctl_t e_decode();
    ctl_t e = base();
    e.alusrcb = 2'b11;
    return e;
  endfunction
  function automatic ctl_t e_memadr();
    ctl_t e = base();
    e.alusrca = 1'b1; e.alusrcb = 2'b10;
    return e;
  endfunction
  function automatic ctl_t e_memrd();
    ctl_t e = base();
    e.iord = 1'b1;
    return e;
  endfunction
  function automatic ctl_t e_memwb();
    ctl_t e = base();
    e.memtoreg = 1'b1; e.regwrite = 1'b1;
    return e;
  endfunction
  function automatic ctl_t e_memwr();
    ctl_t e = base();
    e.iord = 1'b1; e.memwrite = 1'b1;
    return e;
  endfunction
  // {valid, alu code} for an R-type Funct
  function automatic logic [3:0] ref_rtype(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b1010;
      6'b100010: return 4'b1110;
      6'b100100: return 4'b1000;
      6'b100101: return 4'b1001;
      6'b101010: return 4'b1111;
      default:   return 4'b0010;
    endcase
  endfunction
  function automatic ctl_t e_exec_r(input logic [5:0] f);
    ctl_t       e = base();
    logic [3:0] r = ref_rtype(f);
    e.alusrca = 1'b1; e.alusrcb = 2'b00; e.aluctl = r[2:0];
    return e;
  endfunction
  function automatic ctl_t e_aluwb();
    ctl_t e = base();
    e.regdst = 1'b1; e.regwrite = 1'b1;
    return e;
  endfunction
  function automatic ctl_t e_exec_i(input logic [5:0] op);
    ctl_t e = base();
    e.alusrca = 1'b1; e.alusrcb = 2'b10;
    if (op == 6'b001100) begin e.aluctl = 3'b000; e.immzext = 1'b1; end
    if (op == 6'b001101) begin e.aluctl = 3'b001; e.immzext = 1'b1; end
    return e;
  endfunction
  function automatic ctl_t e_iwb();
    ctl_t e = base();
    e.regwrite = 1'b1;
    return e;
  endfunction
  function automatic ctl_t e_branch(input logic [5:0] op);
    ctl_t e = base();
    e.alusrca = 1'b1; e.alusrcb = 2'b00; e.aluctl = 3'b110; e.pcsrc = 2'b01;
    e.branch = (op == 6'b000100); e.branchne = (op == 6'b000101);
    return e;
  endfunction
  function automatic ctl_t e_jump();
    ctl_t e = base();
    e.pcsrc = 2'b10; e.pcwrite = 1'b1;
    return e;
  endfunction
  function automatic ctl_t e_trap(input logic ill, input logic bus);
    ctl_t e = base();
    e.illegal = ill; e.buserr = bus;
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic chk, input logic r, input logic mr,
                               input logic [5:0] op, input logic [5:0] fn, input ctl_t e);
    step_t s;
    s.chk = chk; s.rst = r; s.mr = mr; s.op = op; s.fn = fn; s.exp = e;
    q.push_back(s);
  endfunction

  // Reset out of any state: the second reset cycle already shows FETCH with flags clear
  function automatic void push_reset(input logic [5:0] op, input logic [5:0] fn);
    push(1'b0, 1'b1, rbit(), op, fn, base());
    push(1'b1, 1'b1, 1'b0, op, fn, e_fetch(1'b0));
  endfunction

  function automatic void push_trap(input logic [5:0] op, input logic [5:0] fn,
                                    input logic ill, input logic bus);
    push(1'b1, 1'b0, rbit(), op, fn, e_trap(ill, bus));
    push(1'b1, 1'b0, rbit(), op, fn, e_trap(ill, bus));
    push_reset(op, fn);
  endfunction

  // Full expected script for one instruction with wf fetch stalls and wm memory stalls
  function automatic void plan_instr(input logic [5:0] op, input logic [5:0] fn,
                                     input int wf, input int wm);
    logic [3:0] r;
    for (int i = 0; i < wf; i++) push(1'b1, 1'b0, 1'b0, op, fn, e_fetch(1'b0));
    push(1'b1, 1'b0, 1'b1, op, fn, e_fetch(1'b1));
    push(1'b1, 1'b0, rbit(), op, fn, e_decode());
    case (op)
      6'b100011: begin
        push(1'b1, 1'b0, rbit(), op, fn, e_memadr());
        for (int i = 0; i < wm; i++) push(1'b1, 1'b0, 1'b0, op, fn, e_memrd());
        push(1'b1, 1'b0, 1'b1, op, fn, e_memrd());
        push(1'b1, 1'b0, rbit(), op, fn, e_memwb());
      end
      6'b101011: begin
        push(1'b1, 1'b0, rbit(), op, fn, e_memadr());
        for (int i = 0; i < wm; i++) push(1'b1, 1'b0, 1'b0, op, fn, e_memwr());
        push(1'b1, 1'b0, 1'b1, op, fn, e_memwr());
      end
      6'b000000: begin
        r = ref_rtype(fn);
        push(1'b1, 1'b0, rbit(), op, fn, e_exec_r(fn));
        if (r[3]) push(1'b1, 1'b0, rbit(), op, fn, e_aluwb());
        else      push_trap(op, fn, 1'b1, 1'b0);
      end
      6'b001000, 6'b001100, 6'b001101: begin
        push(1'b1, 1'b0, rbit(), op, fn, e_exec_i(op));
        push(1'b1, 1'b0, rbit(), op, fn, e_iwb());
      end
      6'b000100, 6'b000101: push(1'b1, 1'b0, rbit(), op, fn, e_branch(op));
`ifdef MC_CTRL_JUMP_EN
      6'b000010: push(1'b1, 1'b0, rbit(), op, fn, e_jump());
`endif
      default: push_trap(op, fn, 1'b1, 1'b0);
    endcase
  endfunction

  task automatic test_reset();
    q.delete();
    push(1'b0, 1'b1, 1'b1, 6'b000000, 6'b000000, base());
    push(1'b1, 1'b1, 1'b0, 6'b000000, 6'b000000, e_fetch(1'b0));
    foreach (q[i]) begin
      rst = q[i].rst; mem_ready = q[i].mr; Opcode = q[i].op; Funct = q[i].fn;
      @(negedge clk);
      if (q[i].chk) begin
        tests++;
        if (obs !== q[i].exp) begin
          fails++;
          $display("[TB] FAIL reset step %0d: got %h expected %h", i, obs, q[i].exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    q.delete();
    plan_instr(6'b100011, 6'($urandom_range(0, 63)), 0, 0);
    foreach (q[i]) begin
      rst = q[i].rst; mem_ready = q[i].mr; Opcode = q[i].op; Funct = q[i].fn;
      @(negedge clk);
      if (q[i].chk) begin
        tests++;
        if (obs !== q[i].exp) begin
          fails++;
          $display("[TB] FAIL lw step %0d: got %h expected %h", i, obs, q[i].exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_wait();
    q.delete();
    plan_instr(6'b101011, 6'($urandom_range(0, 63)), 0, 3);
    plan_instr(6'b101011, 6'($urandom_range(0, 63)), 2, 14);
    foreach (q[i]) begin
      rst = q[i].rst; mem_ready = q[i].mr; Opcode = q[i].op; Funct = q[i].fn;
      @(negedge clk);
      if (q[i].chk) begin
        tests++;
        if (obs !== q[i].exp) begin
          fails++;
          $display("[TB] FAIL sw_wait step %0d: got %h expected %h", i, obs, q[i].exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns [6] = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    q.delete();
    foreach (fns[k]) plan_instr(6'b000000, fns[k], 0, 0);
    foreach (q[i]) begin
      rst = q[i].rst; mem_ready = q[i].mr; Opcode = q[i].op; Funct = q[i].fn;
      @(negedge clk);
      if (q[i].chk) begin
        tests++;
        if (obs !== q[i].exp) begin
          fails++;
          $display("[TB] FAIL rtype step %0d fn=%b: got %h expected %h", i, q[i].fn, obs, q[i].exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_imm_branch();
    logic [5:0] ops [5] = '{6'b001101, 6'b000101, 6'b001000, 6'b001100, 6'b000100};
    q.delete();
    foreach (ops[k]) plan_instr(ops[k], 6'($urandom_range(0, 63)), k % 2, 0);
    foreach (q[i]) begin
      rst = q[i].rst; mem_ready = q[i].mr; Opcode = q[i].op; Funct = q[i].fn;
      @(negedge clk);
      if (q[i].chk) begin
        tests++;
        if (obs !== q[i].exp) begin
          fails++;
          $display("[TB] FAIL imm_branch step %0d op=%b: got %h expected %h", i, q[i].op, obs, q[i].exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    q.delete();
    plan_instr(6'b000010, 6'($urandom_range(0, 63)), 0, 0);
    plan_instr(6'b100011, 6'($urandom_range(0, 63)), 0, 1);
    foreach (q[i]) begin
      rst = q[i].rst; mem_ready = q[i].mr; Opcode = q[i].op; Funct = q[i].fn;
      @(negedge clk);
      if (q[i].chk) begin
        tests++;
        if (obs !== q[i].exp) begin
          fails++;
          $display("[TB] FAIL jump step %0d: got %h expected %h", i, obs, q[i].exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Watchdog: 15 stalled cycles trap; ready on the 15th stalled-cycle slot wins
  task automatic test_timeout();
    q.delete();
    for (int k = 0; k < 15; k++) push(1'b1, 1'b0, 1'b0, 6'b001000, 6'b0, e_fetch(1'b0));
    push_trap(6'b001000, 6'b0, 1'b0, 1'b1);
    push(1'b1, 1'b0, 1'b1, 6'b100011, 6'b0, e_fetch(1'b1));
    push(1'b1, 1'b0, rbit(), 6'b100011, 6'b0, e_decode());
    push(1'b1, 1'b0, rbit(), 6'b100011, 6'b0, e_memadr());
    for (int k = 0; k < 15; k++) push(1'b1, 1'b0, 1'b0, 6'b100011, 6'b0, e_memrd());
    push_trap(6'b100011, 6'b0, 1'b0, 1'b1);
    plan_instr(6'b001000, 6'b0, 14, 0);
    plan_instr(6'b100011, 6'b0, 0, 14);
    foreach (q[i]) begin
      rst = q[i].rst; mem_ready = q[i].mr; Opcode = q[i].op; Funct = q[i].fn;
      @(negedge clk);
      if (q[i].chk) begin
        tests++;
        if (obs !== q[i].exp) begin
          fails++;
          $display("[TB] FAIL timeout step %0d: got %h expected %h", i, obs, q[i].exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset asserted mid-read together with mem_ready must land in FETCH, not MEMWB
  task automatic test_reset_mid_access();
    q.delete();
    push(1'b1, 1'b0, 1'b1, 6'b100011, 6'b0, e_fetch(1'b1));
    push(1'b1, 1'b0, 1'b0, 6'b100011, 6'b0, e_decode());
    push(1'b1, 1'b0, 1'b0, 6'b100011, 6'b0, e_memadr());
    push(1'b1, 1'b0, 1'b0, 6'b100011, 6'b0, e_memrd());
    push(1'b1, 1'b1, 1'b1, 6'b100011, 6'b0, e_memrd());
    push(1'b1, 1'b0, 1'b0, 6'b100011, 6'b0, e_fetch(1'b0));
    push(1'b1, 1'b1, 1'b0, 6'b100011, 6'b0, e_fetch(1'b0));
    foreach (q[i]) begin
      rst = q[i].rst; mem_ready = q[i].mr; Opcode = q[i].op; Funct = q[i].fn;
      @(negedge clk);
      if (q[i].chk) begin
        tests++;
        if (obs !== q[i].exp) begin
          fails++;
          $display("[TB] FAIL reset_mid step %0d: got %h expected %h", i, obs, q[i].exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [11] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b001000,
                             6'b001100, 6'b001101, 6'b000100, 6'b000101, 6'b000010, 6'b111111};
    logic [5:0] fns [5]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] op, fn;
    q.delete();
    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(0, 10)];
      if (op == 6'b111111) op = 6'($urandom_range(0, 63));
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 4)];
      plan_instr(op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    foreach (q[i]) begin
      rst = q[i].rst; mem_ready = q[i].mr; Opcode = q[i].op; Funct = q[i].fn;
      @(negedge clk);
      if (q[i].chk) begin
        tests++;
        if (obs !== q[i].exp) begin
          fails++;
          $display("[TB] FAIL random step %0d op=%b fn=%b: got %h expected %h",
                   i, q[i].op, q[i].fn, obs, q[i].exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Scenario sequence
  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype();
    test_imm_branch();
    test_jump();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
